// File: rtl/aes_out_serializer_if.sv
// -----------------------------------------------------------------------------
// aes_out_serializer_if
// Groups the block-input and byte-stream signals of aes_out_serializer.
//   valid_in / data_in : 128-bit result blocks from the AES core (no backpressure)
//   byte_out / byte_valid / byte_ready : valid/ready byte stream toward the host
//   full / overflow / count : FIFO status
//   byte_last          : last-byte marker, present only when AES_OUT_LAST_EN is defined
// Modports:
//   master : the environment side (drives blocks and byte_ready)
//   slave  : the serializer side
// CW must match the CW parameter of the serializer it is connected to.
// -----------------------------------------------------------------------------
interface aes_out_serializer_if #(
    parameter int CW = 3
);
    logic          valid_in;
    logic [127:0]  data_in;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          byte_ready;
    logic          full;
    logic          overflow;
    logic [CW-1:0] count;
`ifdef AES_OUT_LAST_EN
    logic          byte_last;

    modport master (
        output valid_in, data_in, byte_ready,
        input  byte_out, byte_valid, full, overflow, count, byte_last
    );

    modport slave (
        input  valid_in, data_in, byte_ready,
        output byte_out, byte_valid, full, overflow, count, byte_last
    );
`else
    modport master (
        output valid_in, data_in, byte_ready,
        input  byte_out, byte_valid, full, overflow, count
    );

    modport slave (
        input  valid_in, data_in, byte_ready,
        output byte_out, byte_valid, full, overflow, count
    );
`endif
endinterface

// File: rtl/aes_out_serializer.sv
// -----------------------------------------------------------------------------
// aes_out_serializer
// Buffers 128-bit AES result blocks in a DEPTH-entry FIFO and emits each block
// as 16 bytes, most significant byte first, on a valid/ready byte stream.
// Blocks arriving while the FIFO is full are dropped and flag a sticky overflow.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : aes_out_serializer_if.slave
//          (valid_in, data_in, byte_ready in; byte_out, byte_valid, full,
//           overflow, count out; byte_last out when AES_OUT_LAST_EN defined)
//
// Parameters:
//   DEPTH : FIFO entries, power of two, >= 2
//   CW    : occupancy count width, clog2(DEPTH+1)
//
// Optional feature macro: AES_OUT_LAST_EN adds byte_last, high on byte index 15.
// -----------------------------------------------------------------------------
module aes_out_serializer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_out_serializer_if.slave  bus
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [127:0]   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           full_q, full_d;
    logic           overflow_q, overflow_d;
    logic [127:0]   shift_q, shift_d;
    logic [3:0]     idx_q, idx_d;

    logic           byte_valid_s;
    logic           accept_s;
    logic           last_acc_s;
    logic           pop_s;
    logic           write_s;
    logic           drop_s;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != {CW{1'b0}}) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                // Stay in SEND when the next block is popped on the last byte.
                if (last_acc_s && (count_q == {CW{1'b0}})) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: byte valid, handshake decode and FIFO pop request
    always_comb begin
        byte_valid_s = 1'b0;
        pop_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                byte_valid_s = 1'b0;
                pop_s        = (count_q != {CW{1'b0}});
            end
            ST_SEND: begin
                byte_valid_s = 1'b1;
                pop_s        = (idx_q == 4'd15) && bus.byte_ready
                               && (count_q != {CW{1'b0}});
            end
            default: begin
                byte_valid_s = 1'b0;
                pop_s        = 1'b0;
            end
        endcase
        accept_s   = byte_valid_s && bus.byte_ready;
        last_acc_s = accept_s && (idx_q == 4'd15);
        // full is the registered flag, so a same-cycle pop cannot rescue a block.
        write_s    = bus.valid_in && !full_q;
        drop_s     = bus.valid_in && full_q;
    end

    // FIFO pointer, occupancy and status next-state logic
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (write_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (write_s && !pop_s) begin
            count_d = count_q + ONE_C;
        end else if (!write_s && pop_s) begin
            count_d = count_q - ONE_C;
        end else begin
            count_d = count_q;
        end

        if (drop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        full_d = (count_d == DEPTH_C);
    end

    // Shift register and byte index next-state logic
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        // A pop (including the back-to-back pop on byte 15) reloads the register.
        if (pop_s) begin
            shift_d = mem_q[rd_ptr_q];
            idx_d   = 4'd0;
        end else if (accept_s) begin
            shift_d = {shift_q[119:0], 8'h00};
            idx_d   = idx_q + 4'd1;
        end else begin
            shift_d = shift_q;
            idx_d   = idx_q;
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            shift_q    <= 128'h0;
            idx_q      <= 4'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.byte_out   = shift_q[127:120];
    assign bus.byte_valid = byte_valid_s;
    assign bus.full       = full_q;
    assign bus.overflow   = overflow_q;
    assign bus.count      = count_q;
`ifdef AES_OUT_LAST_EN
    assign bus.byte_last  = byte_valid_s && (idx_q == 4'd15);
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// -----------------------------------------------------------------------------
// tb_aes_out_serializer
// Directed self-checking bench for aes_out_serializer (DEPTH=4, CW=3).
// -----------------------------------------------------------------------------
module tb_aes_out_serializer;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;
    logic [7:0] rx_q [$];
    int gap_cycles;
    bit ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    aes_out_serializer_if #(.CW(3)) bus ();

    aes_out_serializer #(.DEPTH(4), .CW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_blk(input int k);
        logic [127:0] b;
        b = 128'h0;
        for (int j = 0; j < 16; j++) begin
            b[127-8*j -: 8] = 8'(k * 16 + j);
        end
        return b;
    endfunction

    // Byte sink: drives byte_ready, records accepted bytes, checks stall hold,
    // mid-block valid and (optionally) byte_last.
    task automatic run_sink(input int nbytes, input bit toggle, input int budget);
        int   cyc;
        int   in_blk;
        bit   seen;
        bit   prev_stall;
        logic [7:0] prev_byte;
        cyc = 0; in_blk = 0; seen = 1'b0; prev_stall = 1'b0; prev_byte = 8'h00;
        rx_q.delete();
        gap_cycles = 0;
        while (rx_q.size() < nbytes && cyc < budget) begin
            bus.byte_ready = toggle ? ready_pat[cyc % 4] : 1'b1;
            if (prev_stall) begin
                n_checks++;
                if (bus.byte_valid !== 1'b1 || bus.byte_out !== prev_byte) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b byte=%h, required valid=1 byte=%h",
                             bus.byte_valid, bus.byte_out, prev_byte);
                end
            end
            if (seen && in_blk != 0) begin
                n_checks++;
                if (bus.byte_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mid_block_valid: valid=%b, required 1 (byte %0d)",
                             bus.byte_valid, in_blk);
                end
            end
            if (seen && bus.byte_valid !== 1'b1) gap_cycles++;
`ifdef AES_OUT_LAST_EN
            n_checks++;
            if (bus.byte_last !== ((bus.byte_valid === 1'b1) && in_blk == 15)) begin
                n_fail++;
                $display("FAIL byte_last: got %b, required %b (byte %0d)",
                         bus.byte_last, (bus.byte_valid === 1'b1) && in_blk == 15, in_blk);
            end
`endif
            if (bus.byte_valid === 1'b1) seen = 1'b1;
            if (bus.byte_valid === 1'b1 && bus.byte_ready) begin
                rx_q.push_back(bus.byte_out);
                in_blk = (in_blk + 1) % 16;
            end
            prev_stall = (bus.byte_valid === 1'b1) && !bus.byte_ready;
            prev_byte  = bus.byte_out;
            cyc++;
            tick();
        end
        bus.byte_ready = 1'b0;
        n_checks++;
        if (rx_q.size() != nbytes) begin
            n_fail++;
            $display("FAIL sink_timeout: got %0d bytes, required %0d", rx_q.size(), nbytes);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in = 128'h0;
        bus.byte_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.byte_valid !== 1'b0 || bus.byte_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_stream: valid=%b byte=%h, required 0/00", bus.byte_valid, bus.byte_out);
        end
        n_checks++;
        if (bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_status: full=%b ovf=%b count=%0d, required 0/0/0",
                     bus.full, bus.overflow, bus.count);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_block();
        logic [127:0] e;
        e = 128'h58cf0bfc4d7c72d958cf0bfc4d7c72d9;
        bus.byte_ready = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in = e;
        tick();
        bus.valid_in = 1'b0;
        n_checks++;
        if (bus.byte_valid !== 1'b0 || bus.count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_after_write: valid=%b count=%0d, required 0/1", bus.byte_valid, bus.count);
        end
        tick();
        n_checks++;
        if (bus.byte_valid !== 1'b1 || bus.byte_out !== 8'h58 || bus.count !== 3'd0) begin
            n_fail++;
            $display("FAIL single_latency: valid=%b byte=%h count=%0d, required 1/58/0",
                     bus.byte_valid, bus.byte_out, bus.count);
        end
        run_sink(16, 1'b0, 40);
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== e[127-8*i -: 8]) begin
                n_fail++;
                $display("FAIL single_byte[%0d]: got %h, required %h", i, rx_q[i], e[127-8*i -: 8]);
            end
        end
        n_checks++;
        if (bus.byte_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end_valid: got %b, required 0", bus.byte_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] e;
        e = 128'h58cf0bfc4d7c72d958cf0bfc4d7c72d9;
        bus.valid_in = 1'b1;
        bus.data_in = e;
        tick();
        bus.valid_in = 1'b0;
        run_sink(16, 1'b1, 200);
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== e[127-8*i -: 8]) begin
                n_fail++;
                $display("FAIL bp_byte[%0d]: got %h, required %h", i, rx_q[i], e[127-8*i -: 8]);
            end
        end
        tick();
        n_checks++;
        if (bus.byte_valid !== 1'b0 || bus.count !== 3'd0) begin
            n_fail++;
            $display("FAIL bp_end: valid=%b count=%0d, required 0/0", bus.byte_valid, bus.count);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a;
        logic [127:0] b;
        a = 128'hafffffffffffffffffffffffffffffff;
        b = 128'h000102030405060708090a0b0c0d0e0f;
        bus.valid_in = 1'b1;
        bus.data_in = a;
        tick();
        bus.data_in = b;
        tick();
        bus.valid_in = 1'b0;
        run_sink(32, 1'b0, 80);
        for (int i = 0; i < 32 && i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== ((i < 16) ? a[127-8*i -: 8] : b[127-8*(i-16) -: 8])) begin
                n_fail++;
                $display("FAIL b2b_byte[%0d]: got %h, required %h", i, rx_q[i],
                         (i < 16) ? a[127-8*i -: 8] : b[127-8*(i-16) -: 8]);
            end
        end
        n_checks++;
        if (gap_cycles != 0) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d idle cycles, required 0", gap_cycles);
        end
        n_checks++;
        if (bus.byte_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end_valid: got %b, required 0", bus.byte_valid);
        end
    endtask

    task automatic test_overflow();
        logic [2:0] exp_cnt [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        bit         exp_full [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bit         exp_ovf  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.byte_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            bus.valid_in = 1'b1;
            bus.data_in = mk_blk(k);
            tick();
            n_checks++;
            if (bus.count !== exp_cnt[k-1] || bus.full !== exp_full[k-1] || bus.overflow !== exp_ovf[k-1]) begin
                n_fail++;
                $display("FAIL ovf_fill[%0d]: count=%0d full=%b ovf=%b, required %0d/%b/%b", k,
                         bus.count, bus.full, bus.overflow, exp_cnt[k-1], exp_full[k-1], exp_ovf[k-1]);
            end
        end
        bus.valid_in = 1'b0;
        tick();
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.byte_valid !== 1'b1 || bus.byte_out !== 8'h10) begin
            n_fail++;
            $display("FAIL ovf_sticky: ovf=%b valid=%b byte=%h, required 1/1/10",
                     bus.overflow, bus.byte_valid, bus.byte_out);
        end
        run_sink(80, 1'b0, 200);
        for (int i = 0; i < 80 && i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== 8'((i / 16 + 1) * 16 + (i % 16))) begin
                n_fail++;
                $display("FAIL ovf_byte[%0d]: got %h, required %h", i, rx_q[i],
                         8'((i / 16 + 1) * 16 + (i % 16)));
            end
        end
        tick();
        tick();
        n_checks++;
        if (bus.byte_valid !== 1'b0 || bus.count !== 3'd0 || bus.full !== 1'b0 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drain: valid=%b count=%0d full=%b ovf=%b, required 0/0/0/1",
                     bus.byte_valid, bus.count, bus.full, bus.overflow);
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] c;
        logic [127:0] p;
        c = 128'h00112233445566778899aabbccddeeff;
        p = mk_blk(7);
        bus.valid_in = 1'b1;
        bus.data_in = p;
        tick();
        bus.valid_in = 1'b0;
        run_sink(7, 1'b0, 40);
        n_checks++;
        if (rx_q.size() == 7 && rx_q[6] !== p[127-48 -: 8]) begin
            n_fail++;
            $display("FAIL arst_pre_byte: got %h, required %h", rx_q[6], p[127-48 -: 8]);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.byte_valid !== 1'b0 || bus.count !== 3'd0 || bus.full !== 1'b0
            || bus.overflow !== 1'b0 || bus.byte_out !== 8'h00) begin
            n_fail++;
            $display("FAIL arst_immediate: valid=%b count=%0d full=%b ovf=%b byte=%h, required 0/0/0/0/00",
                     bus.byte_valid, bus.count, bus.full, bus.overflow, bus.byte_out);
        end
        #1;
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.byte_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_idle: valid=%b, required 0", bus.byte_valid);
        end
        bus.valid_in = 1'b1;
        bus.data_in = c;
        tick();
        bus.valid_in = 1'b0;
        run_sink(16, 1'b0, 40);
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== c[127-8*i -: 8]) begin
                n_fail++;
                $display("FAIL arst_new_byte[%0d]: got %h, required %h", i, rx_q[i], c[127-8*i -: 8]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_single_block();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
